// File: rtl/reg_file_gen_if.sv
// ECALL input handshake between the register file and the board I/O controller.
// The register file is the master: it raises io_req and the controller acks with data.
interface reg_file_gen_if #(
    parameter int XLEN = 32
);
    logic            io_req;
    logic            io_sel;
    logic            io_ack;
    logic [XLEN-1:0] io_data;

    modport master (
        output io_req,
        output io_sel,
        input  io_ack,
        input  io_data
    );

    modport slave (
        input  io_req,
        input  io_sel,
        output io_ack,
        output io_data
    );
endinterface

// File: rtl/reg_file_gen.sv
// Parametrised register file: two combinational read ports, one extending write port,
// write-first bypass, and a blocking ECALL input FSM with optional timeout.
module reg_file_gen #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int TUBE_REG  = 31,
    parameter int LED_REG   = 30,
    parameter int SYSNO_REG = 17,
    parameter int ECALL_DST = 10,
    parameter int BYPASS    = 1,
    parameter int TIMEOUT   = 0,
    localparam int AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [1:0]      rs2_size,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [1:0]      wsize,
    input  logic            wunsigned,
    input  logic            ecall_req,
    reg_file_gen_if.master  io,
    output logic            ecall_busy,
    output logic            io_timeout,
    output logic [XLEN-1:0] reg_map_tube,
    output logic [XLEN-1:0] reg_map_led
);

    localparam logic [AW-1:0] TUBE_IDX  = AW'(TUBE_REG);
    localparam logic [AW-1:0] LED_IDX   = AW'(LED_REG);
    localparam logic [AW-1:0] SYSNO_IDX = AW'(SYSNO_REG);
    localparam logic [AW-1:0] DST_IDX   = AW'(ECALL_DST);
    localparam bit            TO_EN     = (TIMEOUT > 0);
    localparam logic [31:0]   TO_LAST   = TO_EN ? 32'(TIMEOUT - 1) : 32'd0;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] regs [NREG];
    logic [0:0]      state;
    logic [31:0]     cnt;
    logic            sel_q;
    logic            to_q;

    logic [XLEN-1:0] wr_ext;
    logic            wr_commit;
    logic [XLEN-1:0] rs2_raw;
    logic [XLEN-1:0] sysno;
    logic            to_hit;
    logic            ec_we;
    logic [XLEN-1:0] ec_val;

    // Sub-word sign/zero extension shared by the write path and rs2 store extraction.
    function automatic logic [XLEN-1:0] extend(
        input logic [XLEN-1:0] d,
        input logic [1:0]      sz,
        input logic            uns
    );
        logic s8;
        logic s16;
        s8  = d[7] & ~uns;
        s16 = d[15] & ~uns;
        case (sz)
            2'b00:   return {{(XLEN-8){s8}}, d[7:0]};
            2'b01:   return {{(XLEN-16){s16}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign wr_ext    = extend(wdata, wsize, wunsigned);
    assign wr_commit = we && !stall_in && (rd_addr != '0);
    assign sysno     = regs[SYSNO_IDX];

    assign to_hit = TO_EN && (state == S_WAIT) && !io.io_ack && (cnt == TO_LAST);
    assign ec_we  = (state == S_WAIT) && (io.io_ack || to_hit) && (DST_IDX != '0);
    assign ec_val = io.io_ack ? io.io_data : '0;

    assign io.io_req    = (state == S_WAIT);
    assign io.io_sel    = sel_q;
    assign ecall_busy   = (state == S_WAIT);
    assign io_timeout   = to_q;
    assign reg_map_tube = regs[TUBE_IDX];
    assign reg_map_led  = regs[LED_IDX];

    // Read ports: x0 is hard zero; an in-flight normal write is forwarded when enabled.
    always_comb begin
        rs1_data = '0;
        rs2_raw  = '0;
        if (rs1_addr != '0) begin
            if (BYPASS != 0 && wr_commit && rs1_addr == rd_addr)
                rs1_data = wr_ext;
            else
                rs1_data = regs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            if (BYPASS != 0 && wr_commit && rs2_addr == rd_addr)
                rs2_raw = wr_ext;
            else
                rs2_raw = regs[rs2_addr];
        end
    end

    assign rs2_data = extend(rs2_raw, rs2_size, 1'b0);

    // Register array update; the ECALL write is applied last so it wins a collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (wr_commit) regs[rd_addr] <= wr_ext;
            if (ec_we) regs[DST_IDX] <= ec_val;
        end
    end

    // ECALL FSM: pick the input source from a7, wait for ack or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sel_q <= 1'b0;
            cnt   <= '0;
            to_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ecall_req && sysno == '0) begin
                        state <= S_WAIT;
                        sel_q <= 1'b0;
                        cnt   <= '0;
                    end else if (ecall_req && sysno == ONE) begin
                        state <= S_WAIT;
                        sel_q <= 1'b1;
                        cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (io.io_ack) begin
                        state <= S_IDLE;
                    end else if (to_hit) begin
                        state <= S_IDLE;
                        to_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_gen.sv
// Directed bench for reg_file_gen with a scoreboard queue of expected values.
// Uses TIMEOUT=4 so the timeout path and acked ECALLs share one instance.
module tb_reg_file_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [1:0]  rs2_size;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] wdata;
    logic [1:0]  wsize;
    logic        wunsigned;
    logic        ecall_req;
    logic        ecall_busy;
    logic        io_timeout;
    logic [31:0] reg_map_tube;
    logic [31:0] reg_map_led;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];

    reg_file_gen_if #(.XLEN(32)) io ();

    reg_file_gen #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs2_size     (rs2_size),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .we           (we),
        .rd_addr      (rd_addr),
        .wdata        (wdata),
        .wsize        (wsize),
        .wunsigned    (wunsigned),
        .ecall_req    (ecall_req),
        .io           (io),
        .ecall_busy   (ecall_busy),
        .io_timeout   (io_timeout),
        .reg_map_tube (reg_map_tube),
        .reg_map_led  (reg_map_led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %h required nothing", obs);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic uns);
        we        = 1'b1;
        rd_addr   = a;
        wdata     = d;
        wsize     = sz;
        wunsigned = uns;
        tick();
        we        = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] a);
        rs1_addr = a;
        #1;
    endtask

    int n;

    initial begin
        reset      = 1'b1;
        stall_in   = 1'b0;
        rs1_addr   = '0;
        rs2_addr   = '0;
        rs2_size   = 2'b10;
        we         = 1'b0;
        rd_addr    = '0;
        wdata      = '0;
        wsize      = 2'b10;
        wunsigned  = 1'b0;
        ecall_req  = 1'b0;
        io.io_ack  = 1'b0;
        io.io_data = '0;
        tick();
        tick();
        reset = 1'b0;

        push("rst_rs1", 32'h0);
        push("rst_tube", 32'h0);
        push("rst_led", 32'h0);
        push("rst_io_req", 32'h0);
        push("rst_io_sel", 32'h0);
        push("rst_busy", 32'h0);
        push("rst_timeout", 32'h0);
        rd1(5'd31);
        cmp(rs1_data);
        cmp(reg_map_tube);
        cmp(reg_map_led);
        cmp(32'(io.io_req));
        cmp(32'(io.io_sel));
        cmp(32'(ecall_busy));
        cmp(32'(io_timeout));

        push("x5_word", 32'hDEADBEEF);
        wr(5'd5, 32'hDEADBEEF, 2'b10, 1'b0);
        rd1(5'd5);
        cmp(rs1_data);

        push("x0_bypass", 32'h0);
        we = 1'b1; rd_addr = 5'd0; wdata = 32'h1234; wsize = 2'b10;
        rs1_addr = 5'd0;
        #1;
        cmp(rs1_data);
        push("x0_after", 32'h0);
        tick();
        we = 1'b0;
        rd1(5'd0);
        cmp(rs1_data);

        push("byte_signed", 32'hFFFFFFF0);
        wr(5'd6, 32'h000080F0, 2'b00, 1'b0);
        rd1(5'd6);
        cmp(rs1_data);
        push("byte_unsigned", 32'h000000F0);
        wr(5'd8, 32'h000080F0, 2'b00, 1'b1);
        rd1(5'd8);
        cmp(rs1_data);
        push("half_signed", 32'hFFFF80F0);
        wr(5'd9, 32'h000080F0, 2'b01, 1'b0);
        rd1(5'd9);
        cmp(rs1_data);

        wr(5'd11, 32'h12345680, 2'b10, 1'b0);
        push("rs2_byte", 32'hFFFFFF80);
        push("rs2_half", 32'h00005680);
        push("rs2_word", 32'h12345680);
        rs2_addr = 5'd11;
        rs2_size = 2'b00; #1; cmp(rs2_data);
        rs2_size = 2'b01; #1; cmp(rs2_data);
        rs2_size = 2'b11; #1; cmp(rs2_data);

        wr(5'd7, 32'h11, 2'b10, 1'b0);
        push("bypass_rs1", 32'h55);
        push("bypass_rs2", 32'h55);
        we = 1'b1; rd_addr = 5'd7; wdata = 32'h55; wsize = 2'b10;
        rs1_addr = 5'd7; rs2_addr = 5'd7; rs2_size = 2'b10;
        #1;
        cmp(rs1_data);
        cmp(rs2_data);
        tick();
        we = 1'b0;
        push("bypass_after", 32'h55);
        #1; cmp(rs1_data);

        push("stall_old", 32'h55);
        push("stall_after", 32'h55);
        we = 1'b1; stall_in = 1'b1; rd_addr = 5'd7; wdata = 32'h99;
        #1; cmp(rs1_data);
        tick();
        we = 1'b0; stall_in = 1'b0;
        #1; cmp(rs1_data);

        push("tube", 32'hCAFE0001);
        push("led", 32'h0000BEEF);
        wr(5'd31, 32'hCAFE0001, 2'b10, 1'b0);
        wr(5'd30, 32'h0000BEEF, 2'b10, 1'b0);
        cmp(reg_map_tube);
        cmp(reg_map_led);

        wr(5'd17, 32'd1, 2'b10, 1'b0);
        push("ec1_io_req", 32'h1);
        push("ec1_io_sel", 32'h1);
        push("ec1_busy", 32'h1);
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        cmp(32'(io.io_req));
        cmp(32'(io.io_sel));
        cmp(32'(ecall_busy));
        tick();
        tick();
        io.io_ack = 1'b1; io.io_data = 32'hA5;
        push("ec1_x10", 32'hA5);
        push("ec1_req_low", 32'h0);
        push("ec1_busy_low", 32'h0);
        push("ec1_no_timeout", 32'h0);
        tick();
        io.io_ack = 1'b0;
        rd1(5'd10);
        cmp(rs1_data);
        cmp(32'(io.io_req));
        cmp(32'(ecall_busy));
        cmp(32'(io_timeout));

        push("idle_ack_ignored", 32'hA5);
        io.io_ack = 1'b1; io.io_data = 32'hFF;
        tick();
        io.io_ack = 1'b0;
        #1; cmp(rs1_data);

        wr(5'd17, 32'd5, 2'b10, 1'b0);
        push("ec5_no_req", 32'h0);
        push("ec5_no_busy", 32'h0);
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        cmp(32'(io.io_req));
        cmp(32'(ecall_busy));

        wr(5'd17, 32'd0, 2'b10, 1'b0);
        push("to_sel", 32'h0);
        push("to_cycles", 32'd4);
        push("to_x10", 32'h0);
        push("to_flag", 32'h1);
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        cmp(32'(io.io_sel));
        n = 0;
        while (io.io_req && n < 20) begin
            n++;
            tick();
        end
        cmp(32'(n));
        rd1(5'd10);
        cmp(rs1_data);
        cmp(32'(io_timeout));

        wr(5'd17, 32'd1, 2'b10, 1'b0);
        push("ec2_x10", 32'h42);
        push("ec2_flag_sticky", 32'h1);
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        io.io_ack = 1'b1; io.io_data = 32'h42;
        tick();
        io.io_ack = 1'b0;
        rd1(5'd10);
        cmp(rs1_data);
        cmp(32'(io_timeout));

        push("same_cycle_ack_req", 32'h1);
        push("same_cycle_ack_x10", 32'h42);
        ecall_req = 1'b1; io.io_ack = 1'b1; io.io_data = 32'h33;
        tick();
        ecall_req = 1'b0; io.io_ack = 1'b0;
        #1;
        cmp(32'(io.io_req));
        cmp(rs1_data);

        push("wait_rst_req", 32'h0);
        push("wait_rst_busy", 32'h0);
        push("wait_rst_x10", 32'h0);
        push("wait_rst_x5", 32'h0);
        push("wait_rst_tube", 32'h0);
        push("wait_rst_flag", 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        cmp(32'(io.io_req));
        cmp(32'(ecall_busy));
        rd1(5'd10); cmp(rs1_data);
        rd1(5'd5);  cmp(rs1_data);
        cmp(reg_map_tube);
        cmp(32'(io_timeout));

        push("collide_req", 32'h1);
        push("collide_x10", 32'h77);
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        cmp(32'(io.io_req));
        we = 1'b1; rd_addr = 5'd10; wdata = 32'h1111; wsize = 2'b10;
        io.io_ack = 1'b1; io.io_data = 32'h77;
        tick();
        we = 1'b0; io.io_ack = 1'b0;
        rd1(5'd10);
        cmp(rs1_data);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_gen.md
# reg_file_gen

Parametrised register file for the RISC-V core: configurable width and depth, two combinational read ports with store-size extraction and write-first bypass, and one write port with load-size extension. It adds a blocking ECALL input FSM with an io_req/io_ack handshake and an optional timeout. Memory-mapped tube and LED registers are exported as outputs. It sits between decode (read addresses), writeback (write port) and the board I/O controller (ECALL handshake).

## Interface
- XLEN, 32: data width in bits; multiple of 16.
- NREG, 32: register count; power of two, ≥ 32. AW = $clog2(NREG).
- TUBE_REG, 31: index exported on reg_map_tube.
- LED_REG, 30: index exported on reg_map_led.
- SYSNO_REG, 17: syscall-number register (a7).
- ECALL_DST, 10: destination of ECALL input data (a0).
- BYPASS, 1: 1 enables write-first forwarding on the read ports.
- TIMEOUT, 0: ECALL wait limit in cycles; 0 means wait forever.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- stall_in  in  1  when 1, normal writes are suppressed.
- rs1_addr, rs2_addr  in  AW  read addresses.
- rs2_size  in  2  00 byte, 01 half, others word; sign-extends rs2_data for stores.
- rs1_data, rs2_data  out  XLEN  combinational read data.
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- wdata  in  XLEN  write data (ALU result or memory data, already muxed).
- wsize  in  2  00 byte, 01 half, others word.
- wunsigned  in  1  1 zero-extends sub-word writes; 0 sign-extends.
- ecall_req  in  1  one-cycle pulse from decode when ECALL is issued.
- io_req  out  1  request to the I/O controller.
- io_sel  out  1  0 means switches, 1 means keyboard.
- io_ack  in  1  io_data valid this cycle.
- io_data  in  XLEN  input value.
- ecall_busy  out  1  high while the FSM is not IDLE; the core stalls on it.
- io_timeout  out  1  sticky flag; set on timeout.
- reg_map_tube, reg_map_led  out  XLEN  register contents.

## Operation
- Register x0 reads 0 always. Writes to x0 are discarded on every path.
- Write extension: the byte path uses wdata[7:0] and the half path uses wdata[15:0]. The upper bits are sign bits or zeros according to wunsigned. The word path writes wdata unchanged.
- A normal write commits at the clock edge when we=1, stall_in=0 and rd_addr≠0.
- rs2 extraction: byte size gives sign-extended bits [7:0]; half size gives sign-extended bits [15:0].
- Bypass (BYPASS=1): if a normal write is committing this cycle and rs*_addr==rd_addr≠0, the read returns the extended wdata. The ECALL write is never bypassed.
- FSM states:
  - IDLE: io_req=0, busy=0.
  - On ecall_req=1 in IDLE:
    - reg[SYSNO_REG]==0: go to WAIT with io_sel=0.
    - reg[SYSNO_REG]==1: go to WAIT with io_sel=1.
    - any other value: the request is ignored and the FSM stays in IDLE.
  - WAIT: io_req=1, busy=1, io_sel held.
    - io_ack=1: reg[ECALL_DST] ← io_data at that edge, then go to IDLE.
    - Timeout counter expires (TIMEOUT>0 and counter == TIMEOUT−1 without io_ack): reg[ECALL_DST] ← 0, io_timeout ← 1, go to IDLE.
- ecall_req while in WAIT is ignored.
- Write collision: if an ECALL write and a normal write target ECALL_DST in the same cycle, the ECALL write wins.
- stall_in does not affect the FSM.
- io_timeout clears only on reset.

## Timing
- Reset values: every register 0, so rs*_data, reg_map_tube and reg_map_led are all 0. io_req=0, io_sel=0, ecall_busy=0, io_timeout=0. FSM in IDLE, counter 0.
- Reset asserted mid-WAIT: FSM returns to IDLE at that edge and no write occurs.
- Read latency: 0 cycles, combinational.
- Write visibility: next cycle, or the same cycle via bypass.
- ECALL latency:
  - ecall_req at edge N gives io_req=1 and busy=1 from cycle N+1.
  - io_ack sampled at edge M writes at M. io_req=0 from cycle M+1, and the new value is readable in cycle M+1.
- io_ack arriving in the same cycle as ecall_req: ignored, because the FSM is still in IDLE.
- io_ack while in IDLE: ignored.
- Timeout counter: clears on entry to WAIT and increments each WAIT cycle. With TIMEOUT=T, an unanswered request leaves WAIT after exactly T cycles of io_req=1.

## Test plan
- Reset, then write x5=0xDEADBEEF (word). Read x5 the next cycle → 0xDEADBEEF. Write x0=0x1234 → x0 reads 0.
- Sub-word writes with wdata=0x000080F0: byte signed → 0xFFFFFFF0; byte unsigned → 0x000000F0; half signed → 0xFFFF80F0. rs2_size=byte on 0x12345680 → rs2_data 0xFFFFFF80.
- Bypass: we=1, rd=7, wdata=0x55, rs1=7 in the same cycle → rs1_data=0x55. Same stimulus with stall_in=1 → old value, and x7 is unchanged afterwards.
- ECALL with a7=1: ecall_req pulse → io_req=1, io_sel=1, busy=1 the next cycle. io_ack after 3 wait cycles with io_data=0xA5 → x10=0xA5, io_req=0 the next cycle. Same stimulus with a7=5 → no io_req.
- TIMEOUT=4, a7=0, no ack: io_req high for exactly 4 cycles, then x10=0 and io_timeout=1. A later successful ECALL leaves io_timeout=1.
- Reset pulsed in WAIT → io_req=0 and busy=0 the next cycle, all registers 0. Normal write to x10 together with io_ack=1 (io_data=0x77) → x10=0x77.
